// File: rtl/mem_stage_sbuf.sv
// mem_stage_sbuf: N-lane memory stage with a shared circular store buffer.
//
// Lanes issue in-order bundles (lane 0 oldest) of loads, stores and ALU
// pass-throughs. Stores queue in an SB_DEPTH-entry circular buffer that
// drains one entry per cycle into an internal word-addressed data RAM.
// Loads merge bytes from older store lanes of the same bundle, then from
// the buffer (youngest entry first), then from the RAM. Every load is
// therefore architecturally correct, with one registered cycle of latency.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   valid_i[L]        lane carries an instruction
//   mem_write[L]      lane is a store (overrides result_src)
//   result_src[L]     1 = write back load data, 0 = write back ALU value
//   alu_result[L*W]   per-lane byte address / ALU value
//   wdata[L*W]        per-lane store data
//   byte_en[L*W/8]    per-lane store byte mask
//   stall_o           bundle not accepted this cycle (combinational)
//   result[L*W]       registered writeback value (0 for idle lanes)
//   result_valid[L]   registered lane-valid
//   sb_count          occupied store-buffer entries
//   sb_empty          sb_count == 0
module mem_stage_sbuf #(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int SB_DEPTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              valid_i,
    input  logic [LANES-1:0]              mem_write,
    input  logic [LANES-1:0]              result_src,
    input  logic [LANES*DATA_WIDTH-1:0]   alu_result,
    input  logic [LANES*DATA_WIDTH-1:0]   wdata,
    input  logic [LANES*DATA_WIDTH/8-1:0] byte_en,
    output logic                          stall_o,
    output logic [LANES*DATA_WIDTH-1:0]   result,
    output logic [LANES-1:0]              result_valid,
    output logic [$clog2(SB_DEPTH):0]     sb_count,
    output logic                          sb_empty
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int PW    = $clog2(SB_DEPTH);
    localparam int CW    = PW + 1;

    // Control state
    logic [PW-1:0]             r_head;
    logic [PW-1:0]             r_tail;
    logic [CW-1:0]             r_count;
    logic [LANES*DATA_WIDTH-1:0] r_result;
    logic [LANES-1:0]          r_result_valid;

    // Store-buffer storage and data RAM
    logic [AW-1:0]             r_sb_word [SB_DEPTH];
    logic [DATA_WIDTH-1:0]     r_sb_data [SB_DEPTH];
    logic [BYTES-1:0]          r_sb_mask [SB_DEPTH];
    logic [DATA_WIDTH-1:0]     r_mem     [MEM_WORDS];

    // Lane decode
    logic [LANES-1:0]          w_is_store;
    logic [LANES-1:0]          w_is_load;
    logic [AW-1:0]             w_word     [LANES];
    logic [PW-1:0]             w_slot     [LANES];
    logic [CW-1:0]             w_nstores;
    logic [CW-1:0]             w_free;
    logic                      w_drain;
    logic                      w_accept;
    logic [DATA_WIDTH-1:0]     w_lane_val [LANES];

    // Decode each lane and assign store slots in lane order.
    always_comb begin
        logic [CW-1:0] v_cnt;
        // NOTE: a running count inside combinational logic needs blocking
        // assignments so each lane sees the stores of the lanes before it.
        v_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_is_store[i] = valid_i[i] & mem_write[i];
            w_is_load[i]  = valid_i[i] & ~mem_write[i] & result_src[i];
            // Bits [1:0] and everything above the RAM index are ignored.
            w_word[i]     = alu_result[i*DATA_WIDTH+2 +: AW];
            w_slot[i]     = r_tail + v_cnt[PW-1:0];
            v_cnt         = v_cnt + CW'(w_is_store[i]);
        end
        w_nstores = v_cnt;
    end

    // A non-empty buffer always drains its head this cycle, so that slot
    // counts as free for the incoming bundle.
    assign w_drain  = (r_count != '0);
    assign w_free   = CW'(SB_DEPTH) - r_count + CW'(w_drain);
    assign stall_o  = (w_nstores > w_free);
    assign w_accept = ~stall_o;

    // Byte-accurate load value: RAM, then buffer oldest-to-youngest, then
    // older lanes of this bundle; later overrides win, giving the priority
    // order lane > youngest buffer entry > RAM.
    always_comb begin
        logic [DATA_WIDTH-1:0] v_val;
        logic [PW-1:0]         v_idx;
        // NOTE: every variable gets a default before any conditional write
        // so no latch is inferred.
        v_val = '0;
        v_idx = '0;
        for (int i = 0; i < LANES; i++) begin
            v_val = r_mem[w_word[i]];
            for (int k = 0; k < SB_DEPTH; k++) begin
                v_idx = r_head + PW'(k);
                if ((CW'(k) < r_count) && (r_sb_word[v_idx] == w_word[i])) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (r_sb_mask[v_idx][b]) begin
                            v_val[b*8 +: 8] = r_sb_data[v_idx][b*8 +: 8];
                        end
                    end
                end
            end
            // Only strictly older lanes forward; a store never reaches its
            // own lane or anything older.
            for (int j = 0; j < i; j++) begin
                if (w_is_store[j] && (w_word[j] == w_word[i])) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (byte_en[j*BYTES+b]) begin
                            v_val[b*8 +: 8] = wdata[j*DATA_WIDTH+b*8 +: 8];
                        end
                    end
                end
            end
            w_lane_val[i] = w_is_load[i] ? v_val : alu_result[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pointers, occupancy and the writeback register.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_result       <= '0;
            r_result_valid <= '0;
        end else begin
            r_head  <= r_head + PW'(w_drain);
            if (w_accept) begin
                r_tail <= r_tail + w_nstores[PW-1:0];
            end
            r_count <= r_count + (w_accept ? w_nstores : '0) - CW'(w_drain);
            for (int i = 0; i < LANES; i++) begin
                r_result_valid[i] <= valid_i[i] & w_accept;
                r_result[i*DATA_WIDTH +: DATA_WIDTH] <=
                    (valid_i[i] & w_accept) ? w_lane_val[i] : '0;
            end
        end
    end

    // Buffer entries are written at enqueue time.
    // NOTE: storage arrays are deliberately not reset; occupancy is governed
    // by head/count, and stale contents are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_accept && w_is_store[i]) begin
                r_sb_word[w_slot[i]] <= w_word[i];
                r_sb_data[w_slot[i]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
                r_sb_mask[w_slot[i]] <= byte_en[i*BYTES +: BYTES];
            end
        end
    end

    // Drain the head entry into RAM, enabled bytes only. Reset clears the
    // count, so nothing drains while rst is asserted.
    always_ff @(posedge clk) begin
        if (w_drain) begin
            for (int b = 0; b < BYTES; b++) begin
                if (r_sb_mask[r_head][b]) begin
                    r_mem[r_sb_word[r_head]][b*8 +: 8] <= r_sb_data[r_head][b*8 +: 8];
                end
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign sb_count     = r_count;
    assign sb_empty     = (r_count == '0);

endmodule

// File: tb/tb_mem_stage_sbuf.sv
// tb_mem_stage_sbuf: directed and randomized bench for mem_stage_sbuf.
// The reference model keeps the store buffer as a queue of pending stores
// and the RAM as a plain word array, and derives every expected value from
// the acceptance, drain and forwarding rules.
module tb_mem_stage_sbuf;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int SBD   = 4;
    localparam int MW    = 1024;
    localparam int AW    = 10;
    localparam int BY    = DW / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES-1:0]      valid_i;
    logic [LANES-1:0]      mem_write;
    logic [LANES-1:0]      result_src;
    logic [LANES*DW-1:0]   alu_result;
    logic [LANES*DW-1:0]   wdata;
    logic [LANES*BY-1:0]   byte_en;
    logic                  stall_o;
    logic [LANES*DW-1:0]   result;
    logic [LANES-1:0]      result_valid;
    logic [2:0]            sb_count;
    logic                  sb_empty;

    mem_stage_sbuf #(
        .LANES(LANES), .DATA_WIDTH(DW), .SB_DEPTH(SBD), .MEM_WORDS(MW)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_write(mem_write),
        .result_src(result_src), .alu_result(alu_result), .wdata(wdata),
        .byte_en(byte_en), .stall_o(stall_o), .result(result),
        .result_valid(result_valid), .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          word;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_t;

    sb_t         q[$];
    logic [31:0] mem_model [MW];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        last_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [63:0] a, input int lane);
        return int'(a[lane*DW+2 +: AW]);
    endfunction

    // Load value from the rules: RAM, overlaid by pending stores oldest to
    // youngest, overlaid by older store lanes of the same bundle.
    function automatic logic [31:0] model_load(input int i, input logic [1:0] v,
            input logic [1:0] mw, input logic [63:0] a, input logic [63:0] d,
            input logic [7:0] be);
        int          w;
        logic [31:0] val;
        w   = word_of(a, i);
        val = mem_model[w];
        foreach (q[k]) begin
            if (q[k].word == w) begin
                for (int b = 0; b < BY; b++)
                    if (q[k].mask[b]) val[b*8 +: 8] = q[k].data[b*8 +: 8];
            end
        end
        for (int j = 0; j < i; j++) begin
            if (v[j] && mw[j] && word_of(a, j) == w) begin
                for (int b = 0; b < BY; b++)
                    if (be[j*BY+b]) val[b*8 +: 8] = d[j*DW+b*8 +: 8];
            end
        end
        return val;
    endfunction

    // One bundle: drive at negedge, check stall, advance the model, check
    // registered outputs just after the next rising edge.
    task automatic step(input logic [1:0] v, input logic [1:0] mw, input logic [1:0] rs,
            input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        int          nst;
        int          fr;
        logic        exp_stall;
        logic        exp_val [LANES];
        logic [31:0] exp_res [LANES];
        sb_t         e;
        @(negedge clk);
        valid_i = v; mem_write = mw; result_src = rs;
        alu_result = a; wdata = d; byte_en = be;
        #1;
        nst = 0;
        for (int i = 0; i < LANES; i++) if (v[i] && mw[i]) nst++;
        fr = SBD - q.size() + ((q.size() > 0) ? 1 : 0);
        exp_stall = (nst > fr);
        last_stall = stall_o;
        check("stall", 64'(stall_o), 64'(exp_stall));
        for (int i = 0; i < LANES; i++) begin
            exp_val[i] = v[i] && !exp_stall;
            if (!exp_val[i])               exp_res[i] = '0;
            else if (mw[i] || !rs[i])      exp_res[i] = a[i*DW +: DW];
            else                           exp_res[i] = model_load(i, v, mw, a, d, be);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int b = 0; b < BY; b++)
                if (e.mask[b]) mem_model[e.word][b*8 +: 8] = e.data[b*8 +: 8];
        end
        if (!exp_stall) begin
            for (int i = 0; i < LANES; i++)
                if (v[i] && mw[i])
                    q.push_back('{word_of(a, i), d[i*DW +: DW], be[i*BY +: BY]});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("valid%0d", i), 64'(result_valid[i]), 64'(exp_val[i]));
            if (!exp_stall)
                check($sformatf("result%0d", i), 64'(result[i*DW +: DW]), 64'(exp_res[i]));
        end
        check("sb_count", 64'(sb_count), 64'(q.size()));
        check("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
        check("count_bound", 64'(sb_count <= 3'(SBD)), 64'(1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 2'b00, 2'b00, '0, '0, '0);
    endtask

    task automatic store0(input logic [31:0] addr, input logic [31:0] data);
        step(2'b01, 2'b01, 2'b00, {32'h0, addr}, {32'h0, data}, 8'h0F);
    endtask

    task automatic load0(input logic [31:0] addr);
        step(2'b01, 2'b00, 2'b01, {32'h0, addr}, '0, '0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic midrun_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_result", 64'(result), 64'(0));
        check("rst_valid", 64'(result_valid), 64'(0));
        check("rst_count", 64'(sb_count), 64'(0));
        check("rst_empty", 64'(sb_empty), 64'(1));
        valid_i = '0; mem_write = '0; result_src = '0;
        alu_result = '0; wdata = '0; byte_en = '0;
        q.delete();
        last_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
             | (32'($urandom_range(0, 7)) << 12);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rv, rmw, rrs;
        logic [63:0] ra, rd;
        logic [7:0]  rbe;

        rst = 1'b1;
        valid_i = '0; mem_write = '0; result_src = '0;
        alu_result = '0; wdata = '0; byte_en = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", 64'(result), 64'(0));
        check("reset_valid", 64'(result_valid), 64'(0));
        check("reset_count", 64'(sb_count), 64'(0));
        check("reset_empty", 64'(sb_empty), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Forward from the buffer before the RAM drain lands.
        store0(32'h40, 32'hDEADBEEF);
        load0(32'h40);
        check("fwd_buffer", 64'(result[31:0]), 64'(32'hDEADBEEF));

        // Intra-bundle byte merge: lane0 store mask 0101, lane1 load.
        store0(32'h10, 32'h11223344);
        idle(2);
        step(2'b11, 2'b01, 2'b10, {32'h10, 32'h10}, {32'h0, 32'hAABBCCDD}, 8'h05);
        check("fwd_merge", 64'(result[63:32]), 64'(32'h11BB33DD));
        // Younger store lane must not forward to an older load lane.
        store0(32'h10, 32'h11223344);
        idle(2);
        step(2'b11, 2'b10, 2'b01, {32'h10, 32'h10}, {32'hAABBCCDD, 32'h0}, 8'hF0);
        check("fwd_isolation", 64'(result[31:0]), 64'(32'h11223344));

        // Youngest store wins, and the drained RAM agrees.
        store0(32'h8, 32'h1);
        store0(32'h8, 32'h2);
        store0(32'h8, 32'h3);
        load0(32'h8);
        check("youngest_fwd", 64'(result[31:0]), 64'(32'h3));
        idle(4);
        load0(32'h8);
        check("youngest_ram", 64'(result[31:0]), 64'(32'h3));

        // Fill to 4, then a 2-store bundle stalls; a 1-store bundle fits.
        idle(2);
        for (int k = 0; k < 3; k++)
            step(2'b11, 2'b11, 2'b00, {32'h18, 32'h14}, {$urandom, $urandom}, 8'hFF);
        check("full_count", 64'(sb_count), 64'(4));
        step(2'b11, 2'b11, 2'b00, {32'h18, 32'h14}, {$urandom, $urandom}, 8'hFF);
        check("full_stall", 64'(last_stall), 64'(1));
        check("full_valid", 64'(result_valid), 64'(0));
        step(2'b11, 2'b11, 2'b00, {32'h18, 32'h14}, {$urandom, $urandom}, 8'hFF);
        check("refill_count", 64'(sb_count), 64'(4));
        store0(32'h14, 32'h55AA55AA);
        check("drain_slot_valid", 64'(result_valid[0]), 64'(1));
        check("drain_slot_count", 64'(sb_count), 64'(4));
        idle(5);

        // Address aliasing: 0x1004 maps to word 1.
        store0(32'h1004, 32'hCAFEF00D);
        idle(3);
        load0(32'h4);
        check("alias_word1", 64'(result[31:0]), 64'(32'hCAFEF00D));

        // Initialise words 0..15 before random traffic reads them.
        for (int w = 0; w < 16; w++) store0(32'(w * 4), $urandom);
        idle(2);

        rv = '0; rmw = '0; rrs = '0; ra = '0; rd = '0; rbe = '0;
        for (int n = 0; n < 400; n++) begin
            // A stalled bundle is held and reissued, as upstream would.
            if (!last_stall) begin
                for (int i = 0; i < LANES; i++) begin
                    rv[i]  = ($urandom_range(0, 9) < 8);
                    rmw[i] = $urandom_range(0, 1) == 1;
                    rrs[i] = $urandom_range(0, 1) == 1;
                    ra[i*DW +: DW] = rand_addr();
                    rd[i*DW +: DW] = $urandom;
                    rbe[i*BY +: BY] = 4'($urandom_range(0, 15));
                end
            end
            step(rv, rmw, rrs, ra, rd, rbe);
            if (n == 200) begin
                step(2'b11, 2'b01, 2'b10, {rand_addr(), rand_addr()}, {32'h0, $urandom}, 8'h0F);
                midrun_reset();
            end
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sbuf.md
Name: mem_stage_sbuf

Overview:
- Parametrised N-lane successor to the dual-lane memory stage.
- Lanes issue in-order bundles of loads, stores and ALU pass-throughs.
- Stores are queued in a shared circular store buffer that drains one entry per cycle into an internal word-addressed data RAM.
- Loads forward byte-accurately from the buffer and from older lanes of the same bundle, so writeback data is always architecturally correct, with one registered cycle of latency.

Parameters:
- LANES, 2, number of issue lanes; lane 0 is oldest in a bundle.
- DATA_WIDTH, 32, data/address width; must be a multiple of 8.
- SB_DEPTH, 4, store-buffer entries; power of two, at least LANES.
- MEM_WORDS, 1024, data RAM depth in words; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- valid_i  in  LANES  lane carries an instruction.
- mem_write  in  LANES  lane is a store.
- result_src  in  LANES  1 = writeback load data, 0 = writeback ALU result.
- alu_result  in  LANES*DATA_WIDTH  per-lane byte address / ALU value.
- wdata  in  LANES*DATA_WIDTH  per-lane store data.
- byte_en  in  LANES*DATA_WIDTH/8  per-lane store byte mask.
- stall_o  out  1  bundle not accepted this cycle (combinational).
- result  out  LANES*DATA_WIDTH  registered writeback value.
- result_valid  out  LANES  registered lane-valid.
- sb_count  out  clog2(SB_DEPTH)+1  occupied entries.
- sb_empty  out  1  sb_count == 0.

Behaviour:
- Reset: clock and reset behaviour is fixed as one clock, with reset asynchronous and active-high. Async rst clears head, tail, count, result and result_valid to 0. RAM contents are not reset. Entries pending when rst asserts are discarded, including mid-drain.
- Word index: alu_result[clog2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo MEM_WORDS. Bits [1:0] are ignored; there is no misalignment trap.
- Store lane: a lane is a store when valid_i & mem_write. mem_write overrides result_src, and the lane writes back alu_result.
- Drain: when count>0, the head entry writes its enabled bytes to RAM at the clock edge, then head++. Pointers wrap modulo SB_DEPTH.
- Acceptance:
  - nstores = number of store lanes in the bundle.
  - free = SB_DEPTH - count + (count>0 ? 1 : 0); this includes the slot freed by a same-cycle drain.
  - stall_o = (nstores > free).
  - On stall, no lane is accepted, with no partial acceptance. Next-cycle result_valid = 0. Drain continues. Upstream holds the bundle.
- Enqueue: accepted stores enter at tail in lane order (lane 0 first). Each entry holds {word index, data, mask}. count_next = count + nstores - drain.
- Load value per byte, by priority from highest:
  1. Youngest older store lane in the same bundle matching word and byte.
  2. Youngest matching buffer entry, including the entry draining this cycle.
  3. RAM asynchronous read.
- Output timing: result and result_valid are registered one cycle after acceptance. result_valid[i] = valid_i[i] & ~stall_o. Invalid lanes output result 0.
- Lane isolation: a store never forwards to its own lane or to older lanes.
- Simultaneous events: enqueue and drain in the same cycle to the same slot are not possible, because free accounting prevents it. A full buffer with a drain accepts up to 1 store.

Test Plan:
- Reset and idle: rst pulse mid-run -> result=0, result_valid=0, sb_count=0, sb_empty=1 immediately (asynchronous).
- Buffer forward: lane0 store 0xDEADBEEF @0x40 mask 0xF; next cycle lane0 load @0x40 -> result=0xDEADBEEF before the RAM drain completes.
- Intra-bundle and byte-merge forward:
  - Setup: RAM[0x10]=0x11223344. Lane0 store 0xAABBCCDD @0x10 mask 0b0101; lane1 load @0x10 in the same bundle.
  - Check: lane1 result=0x11BB33DD.
  - Check: swapped lanes (load lane0, store lane1) -> load result=0x11223344.
- Youngest wins: three queued stores to @0x8 (0x1, 0x2, 0x3, all masks 0xF), then load @0x8 -> 0x3. After a 4-cycle drain, RAM[2]=0x3.
- Full/stall:
  - Setup: SB_DEPTH=4. Fill 4 entries with drain blocked by back-to-back bundles, then issue a 2-store bundle.
  - Check: stall_o=1 and result_valid=0 next cycle.
  - Check: a 1-store bundle at count=4 is accepted (drain slot); count stays 4.
- Wrap: address 0x1000+0x4 with MEM_WORDS=1024 aliases word 1. Pointer wrap verified over 10 enqueue/drain cycles; sb_count never exceeds 4.
